// File: rtl/irq_trap_sequencer_if.sv
// Trap request handshake between the interrupt sequencer and the CSR file.
// master: drives trap_req/trap_cause/trap_mepc, receives trap_ack.
interface irq_trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            trap_req;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_mepc;
  logic            trap_ack;

  modport master (
    output trap_req,
    output trap_cause,
    output trap_mepc,
    input  trap_ack
  );

  modport slave (
    input  trap_req,
    input  trap_cause,
    input  trap_mepc,
    output trap_ack
  );
endinterface

// File: rtl/irq_trap_sequencer.sv
// Machine-mode interrupt sequencer: syncs MEIP/MTIP/MSIP, issues held traps, WFI.
// Ports: clk_i/rst_i, irq lines, mie/mstatus, retire info, trap_if (master), mip/wfi/cnt.
module irq_trap_sequencer #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             meip_i,
  input  logic             mtip_i,
  input  logic             msip_i,
  input  logic [XLEN-1:0]  mie_i,
  input  logic             mstatus_mie_i,
  input  logic             pipe_stall_i,
  input  logic             retire_valid_i,
  input  logic [XLEN-1:0]  retire_pc_i,
  input  logic             exc_valid_i,
  input  logic             wfi_i,
  irq_trap_sequencer_if.master trap_if,
  output logic [XLEN-1:0]  mip_o,
  output logic             wfi_stall_o,
  output logic [CNT_W-1:0] irq_taken_cnt_o
);

  localparam logic [XLEN-1:0] CAUSE_MEI =
    {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CAUSE_MSI =
    {1'b1, {(XLEN-5){1'b0}}, 4'h3};
  localparam logic [XLEN-1:0] CAUSE_MTI =
    {1'b1, {(XLEN-5){1'b0}}, 4'h7};

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    REQ,
    COOL,
    WFI
  } state_t;

  state_t state_q;

  logic [SYNC_STAGES-1:0] meip_sync;
  logic [SYNC_STAGES-1:0] mtip_sync;
  logic [SYNC_STAGES-1:0] msip_sync;

  logic            req_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] mepc_q;
  logic            stall_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN-1:0] en;
  logic [XLEN-1:0] wake;
  logic [XLEN-1:0] sel_cause;
  logic            clean_retire;

  // Bit 0 takes the raw line; the top bit is the synchronized level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meip_sync <= '0;
      mtip_sync <= '0;
      msip_sync <= '0;
    end else begin
      meip_sync <= {meip_sync[SYNC_STAGES-2:0], meip_i};
      mtip_sync <= {mtip_sync[SYNC_STAGES-2:0], mtip_i};
      msip_sync <= {msip_sync[SYNC_STAGES-2:0], msip_i};
    end
  end

  always_comb begin
    mip_o     = '0;
    mip_o[11] = meip_sync[SYNC_STAGES-1];
    mip_o[7]  = mtip_sync[SYNC_STAGES-1];
    mip_o[3]  = msip_sync[SYNC_STAGES-1];
  end

  assign en   = mip_o & mie_i & {XLEN{mstatus_mie_i}};
  assign wake = mip_o & mie_i;

  assign clean_retire = retire_valid_i
                      & ~pipe_stall_i
                      & ~exc_valid_i;

  // Fixed priority MEI > MSI > MTI; overlapping bits are expected.
  always_comb begin
    sel_cause = '0;
    priority case (1'b1)
      en[11]:  sel_cause = CAUSE_MEI;
      en[3]:   sel_cause = CAUSE_MSI;
      en[7]:   sel_cause = CAUSE_MTI;
      default: sel_cause = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      cause_q <= '0;
      mepc_q  <= '0;
      stall_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if ((en != '0) && !exc_valid_i) begin
            state_q <= ARM;
          end else if (wfi_i) begin
            state_q <= WFI;
            stall_q <= 1'b1;
          end
        end
        ARM: begin
          if (en == '0) begin
            state_q <= IDLE;
          end else if (clean_retire) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            cause_q <= sel_cause;
            mepc_q  <= retire_pc_i;
          end
        end
        REQ: begin
          // Held until ack; cause/mepc frozen even if en drops.
          if (trap_if.trap_ack) begin
            state_q <= COOL;
            req_q   <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        COOL: begin
          // Gives the CSR file a cycle to clear mstatus.MIE.
          state_q <= IDLE;
        end
        WFI: begin
          if (wake != '0) begin
            state_q <= IDLE;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign trap_if.trap_req   = req_q;
  assign trap_if.trap_cause = cause_q;
  assign trap_if.trap_mepc  = mepc_q;
  assign wfi_stall_o        = stall_q;
  assign irq_taken_cnt_o    = cnt_q;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Directed bench for irq_trap_sequencer.
// Drives on negedge, checks on negedge (or mid-cycle for async reset).
module tb_irq_trap_sequencer;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             meip;
  logic             mtip;
  logic             msip;
  logic [XLEN-1:0]  mie;
  logic             mstatus_mie;
  logic             pipe_stall;
  logic             retire_valid;
  logic [XLEN-1:0]  retire_pc;
  logic             exc_valid;
  logic             wfi;
  logic [XLEN-1:0]  mip;
  logic             wfi_stall;
  logic [CNT_W-1:0] cnt;

  int checks;
  int errors;

  irq_trap_sequencer_if #(.XLEN(XLEN)) tif ();

  irq_trap_sequencer #(
    .XLEN(XLEN),
    .SYNC_STAGES(2),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .meip_i         (meip),
    .mtip_i         (mtip),
    .msip_i         (msip),
    .mie_i          (mie),
    .mstatus_mie_i  (mstatus_mie),
    .pipe_stall_i   (pipe_stall),
    .retire_valid_i (retire_valid),
    .retire_pc_i    (retire_pc),
    .exc_valid_i    (exc_valid),
    .wfi_i          (wfi),
    .trap_if        (tif.master),
    .mip_o          (mip),
    .wfi_stall_o    (wfi_stall),
    .irq_taken_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen_req;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    meip         = 1'b0;
    mtip         = 1'b0;
    msip         = 1'b0;
    mie          = '0;
    mstatus_mie  = 1'b0;
    pipe_stall   = 1'b0;
    retire_valid = 1'b0;
    retire_pc    = '0;
    exc_valid    = 1'b0;
    wfi          = 1'b0;
    tif.trap_ack = 1'b0;

    tick(2);
    chk("rst_mip", mip, 32'h0);
    chk("rst_req", {31'b0, tif.trap_req}, 32'h0);
    chk("rst_cause", tif.trap_cause, 32'h0);
    chk("rst_mepc", tif.trap_mepc, 32'h0);
    chk("rst_stall", {31'b0, wfi_stall}, 32'h0);
    chk("rst_cnt", {16'b0, cnt}, 32'h0);
    rst = 1'b0;
    tick(1);

    // Priority: MEI beats MTI, then MTI taken second.
    mie         = 32'h888;
    mstatus_mie = 1'b1;
    meip        = 1'b1;
    mtip        = 1'b1;
    tick(2);
    chk("prio_mip", mip, 32'h880);
    tick(1);
    chk("prio_noreq", {31'b0, tif.trap_req}, 32'h0);
    retire_valid = 1'b1;
    retire_pc    = 32'h100;
    tick(1);
    retire_valid = 1'b0;
    chk("prio_req", {31'b0, tif.trap_req}, 32'h1);
    chk("prio_cause", tif.trap_cause, 32'h8000_000B);
    chk("prio_mepc", tif.trap_mepc, 32'h100);
    tif.trap_ack = 1'b1;
    tick(1);
    tif.trap_ack = 1'b0;
    meip         = 1'b0;
    chk("prio_ackreq", {31'b0, tif.trap_req}, 32'h0);
    chk("prio_cnt1", {16'b0, cnt}, 32'h1);
    tick(3);
    retire_valid = 1'b1;
    retire_pc    = 32'h200;
    tick(1);
    retire_valid = 1'b0;
    chk("prio2_req", {31'b0, tif.trap_req}, 32'h1);
    chk("prio2_cause", tif.trap_cause, 32'h8000_0007);
    chk("prio2_mepc", tif.trap_mepc, 32'h200);
    tif.trap_ack = 1'b1;
    mtip         = 1'b0;
    tick(1);
    tif.trap_ack = 1'b0;
    chk("prio2_cnt", {16'b0, cnt}, 32'h2);
    tick(3);

    // Global mask holds off MSI until mstatus.MIE rises.
    mstatus_mie = 1'b0;
    mie         = 32'h008;
    msip        = 1'b1;
    tick(2);
    chk("mask_mip", mip, 32'h8);
    retire_valid = 1'b1;
    retire_pc    = 32'h300;
    seen_req     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (tif.trap_req) seen_req = 1'b1;
    end
    chk("mask_noreq", {31'b0, seen_req}, 32'h0);
    mstatus_mie = 1'b1;
    tick(2);
    retire_valid = 1'b0;
    chk("mask_req", {31'b0, tif.trap_req}, 32'h1);
    chk("mask_cause", tif.trap_cause, 32'h8000_0003);
    chk("mask_mepc", tif.trap_mepc, 32'h300);
    tif.trap_ack = 1'b1;
    msip         = 1'b0;
    tick(1);
    tif.trap_ack = 1'b0;
    tick(2);
    chk("mask_cnt", {16'b0, cnt}, 32'h3);

    // Stall and exception defer the capture.
    mie  = 32'h800;
    meip = 1'b1;
    tick(3);
    pipe_stall   = 1'b1;
    retire_valid = 1'b1;
    retire_pc    = 32'h20;
    tick(5);
    chk("defer_stall", {31'b0, tif.trap_req}, 32'h0);
    pipe_stall = 1'b0;
    exc_valid  = 1'b1;
    tick(1);
    chk("defer_exc", {31'b0, tif.trap_req}, 32'h0);
    exc_valid = 1'b0;
    retire_pc = 32'h40;
    tick(1);
    chk("defer_req", {31'b0, tif.trap_req}, 32'h1);
    chk("defer_mepc", tif.trap_mepc, 32'h40);
    chk("defer_cause", tif.trap_cause, 32'h8000_000B);

    // Held request survives withdrawal of the line.
    meip         = 1'b0;
    retire_valid = 1'b0;
    retire_pc    = 32'h999;
    tick(10);
    chk("held_req", {31'b0, tif.trap_req}, 32'h1);
    chk("held_cause", tif.trap_cause, 32'h8000_000B);
    chk("held_mepc", tif.trap_mepc, 32'h40);
    tif.trap_ack = 1'b1;
    tick(1);
    tif.trap_ack = 1'b0;
    chk("held_ackreq", {31'b0, tif.trap_req}, 32'h0);
    chk("held_cnt", {16'b0, cnt}, 32'h4);
    tick(2);

    // WFI wake via MTIP with global enable off.
    mstatus_mie = 1'b0;
    mie         = 32'h080;
    wfi         = 1'b1;
    tick(1);
    wfi = 1'b0;
    chk("wfi_stall", {31'b0, wfi_stall}, 32'h1);
    mtip = 1'b1;
    tick(2);
    chk("wfi_still", {31'b0, wfi_stall}, 32'h1);
    tick(1);
    chk("wfi_wake", {31'b0, wfi_stall}, 32'h0);
    tick(3);
    chk("wfi_noreq", {31'b0, tif.trap_req}, 32'h0);
    mtip = 1'b0;
    tick(3);

    // Async reset while in REQ.
    mstatus_mie  = 1'b1;
    mie          = 32'h800;
    meip         = 1'b1;
    retire_valid = 1'b1;
    retire_pc    = 32'h500;
    tick(4);
    retire_valid = 1'b0;
    chk("abort_req", {31'b0, tif.trap_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_req0", {31'b0, tif.trap_req}, 32'h0);
    chk("abort_cause", tif.trap_cause, 32'h0);
    chk("abort_mepc", tif.trap_mepc, 32'h0);
    chk("abort_mip", mip, 32'h0);
    chk("abort_cnt", {16'b0, cnt}, 32'h0);
    chk("abort_state", {29'b0, dut.state_q}, 32'h0);
    meip = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);

    // Counter wrap from a forced preload.
    force dut.cnt_q = 16'hFFFF;
    tick(1);
    release dut.cnt_q;
    tick(1);
    chk("wrap_pre", {16'b0, cnt}, 32'hFFFF);
    meip         = 1'b1;
    retire_valid = 1'b1;
    retire_pc    = 32'h600;
    tick(4);
    retire_valid = 1'b0;
    chk("wrap_req", {31'b0, tif.trap_req}, 32'h1);
    tif.trap_ack = 1'b1;
    meip         = 1'b0;
    tick(1);
    tif.trap_ack = 1'b0;
    chk("wrap_cnt", {16'b0, cnt}, 32'h0);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
